// File: rtl/nn_pkg.sv
// Shared types for the activation LUT datapath.
// Requester ids and the in-flight tag carried alongside each lookup.
package nn_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int LUT_LAT_DEF = 1;

  typedef enum logic {
    REQ_HID = 1'b0,
    REQ_OUT = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } lut_tag_t;

endpackage

// File: rtl/lut_tag_pipe.sv
// Tag shift register that tracks which requester owns each
// lookup in flight through the fixed-latency LUT.
module lut_tag_pipe
  import nn_pkg::*;
#(
  parameter int LUT_LAT = LUT_LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  input  lut_tag_t push,
  output lut_tag_t tail,
  output logic     any_valid
);

  lut_tag_t stage [LUT_LAT];

  // Shift one tag per cycle; clear drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_LAT; i++) stage[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < LUT_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < LUT_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[LUT_LAT-1];

  // Any valid tag means a lookup is still outstanding.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LUT_LAT; i++)
      any_valid = any_valid | stage[i].valid;
  end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one activation LUT between the hidden and output paths.
// Hidden wins by default; a starved output path is forced ahead.
module lut_arbiter
  import nn_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LUT_LAT    = LUT_LAT_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hid_valid,
  input  logic [DATA_W-1:0] hid_data,
  output logic              hid_ready,
  output logic              hid_resp_valid,
  output logic [DATA_W-1:0] hid_resp_data,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  output logic              out_ready,
  output logic              out_resp_valid,
  output logic [DATA_W-1:0] out_resp_data,
  output logic              lut_en,
  output logic [DATA_W-1:0] lut_in,
  input  logic [DATA_W-1:0] lut_out,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  localparam logic [7:0] STARVE_TH = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;
  logic       starve;
  logic       hid_xfer;
  logic       out_xfer;
  lut_tag_t   push;
  lut_tag_t   tail;

  assign starve = (starve_cnt >= STARVE_TH);

  // Readies depend only on valids and state, never on each other.
  assign hid_ready = reset & !flush & (!out_valid | !starve);
  assign out_ready = reset & !flush & (!hid_valid | starve);

  assign hid_xfer = hid_valid & hid_ready;
  assign out_xfer = out_valid & out_ready;

  assign lut_en = hid_xfer | out_xfer;

  // Forward the winner's operand; idle cycles drive zero.
  always_comb begin
    lut_in = '0;
    if (hid_xfer)
      lut_in = hid_data;
    else if (out_xfer)
      lut_in = out_data;
  end

  assign push.valid = lut_en;
  assign push.id    = out_xfer ? REQ_OUT : REQ_HID;

  lut_tag_pipe #(
    .LUT_LAT (LUT_LAT)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .tail      (tail),
    .any_valid (busy)
  );

  // Count cycles the output path waits; saturate at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!out_valid || out_xfer)
      starve_cnt <= '0;
    else if (starve_cnt != 8'hFF)
      starve_cnt <= starve_cnt + 8'd1;
  end

  // Saturating count of cycles where both paths request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_cnt <= '0;
    else if (hid_valid && out_valid && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end

  // Route the LUT result to whichever path owns the tail tag.
  always_comb begin
    hid_resp_valid = tail.valid & (tail.id == REQ_HID);
    out_resp_valid = tail.valid & (tail.id == REQ_OUT);
    hid_resp_data  = hid_resp_valid ? lut_out : '0;
    out_resp_data  = out_resp_valid ? lut_out : '0;
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Scoreboard bench for lut_arbiter with a behavioural LUT model.
// Driver pushes expected responses; a monitor pops and compares.
module tb_lut_arbiter;

  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int SM  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          hid_valid;
  logic [DW-1:0] hid_data;
  logic          hid_ready;
  logic          hid_resp_valid;
  logic [DW-1:0] hid_resp_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_resp_valid;
  logic [DW-1:0] out_resp_data;
  logic          lut_en;
  logic [DW-1:0] lut_in;
  logic [DW-1:0] lut_out;
  logic          busy;
  logic [15:0]   conflict_cnt;

  lut_arbiter #(
    .DATA_W     (DW),
    .LUT_LAT    (LAT),
    .STARVE_MAX (SM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .hid_valid      (hid_valid),
    .hid_data       (hid_data),
    .hid_ready      (hid_ready),
    .hid_resp_valid (hid_resp_valid),
    .hid_resp_data  (hid_resp_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .out_resp_valid (out_resp_valid),
    .out_resp_data  (out_resp_data),
    .lut_en         (lut_en),
    .lut_in         (lut_in),
    .lut_out        (lut_out),
    .busy           (busy),
    .conflict_cnt   (conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] img(input logic [DW-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction

  logic [DW-1:0] lpipe [LAT];
  always @(posedge clk) begin
    lpipe[0] <= lut_in;
    for (int i = 1; i < LAT; i++) lpipe[i] <= lpipe[i-1];
  end
  assign lut_out = img(lpipe[LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int failures = 0;
  int last_xfer = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d",
               nm, act, req, cyc);
    end
  endtask

  // g: 0 no grant, 1 hid, 2 out; keep: expect a response.
  task automatic step(input logic hv, input logic [DW-1:0] hd,
                      input logic ov, input logic [DW-1:0] od,
                      input logic fl, input int g, input bit keep,
                      input string nm);
    logic [1:0]    got;
    logic [1:0]    ex;
    logic [DW-1:0] ed;
    @(posedge clk);
    #1;
    hid_valid = hv;
    hid_data  = hd;
    out_valid = ov;
    out_data  = od;
    flush     = fl;
    #1;
    got = {out_valid & out_ready, hid_valid & hid_ready};
    ex  = (g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00;
    chk(got == ex, {nm, "_grant"}, 32'(got), 32'(ex));
    if (g != 0) begin
      ed = (g == 1) ? hd : od;
      chk(lut_en && lut_in == ed, {nm, "_lut_in"},
          {15'b0, lut_en, lut_in}, {15'b0, 1'b1, ed});
      last_xfer = cyc;
      if (keep)
        sb.push_back('{id: (g == 2), data: img(ed), due: cyc + LAT});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0, "idle");
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk(1'b0, "resp_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (hid_resp_valid && out_resp_valid) begin
        chk(1'b0, "resp_both", 32'd3, 32'd1);
      end else if (hid_resp_valid || out_resp_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "resp_unexpected", {31'b0, out_resp_valid}, 32'd0);
        end else begin
          exp_t e;
          logic [DW-1:0] d;
          logic [DW-1:0] o;
          e = sb.pop_front();
          d = out_resp_valid ? out_resp_data : hid_resp_data;
          o = out_resp_valid ? hid_resp_data : out_resp_data;
          chk(out_resp_valid == e.id, "resp_id",
              32'(out_resp_valid), 32'(e.id));
          chk(d == e.data, "resp_data", 32'(d), 32'(e.data));
          chk(cyc == e.due, "resp_cycle", 32'(cyc), 32'(e.due));
          chk(o == '0, "resp_other_zero", 32'(o), 32'd0);
        end
      end
    end
  end

  logic [15:0] c0;
  logic [15:0] pat;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    hid_valid = 1'b1;
    hid_data  = 16'h1234;
    out_valid = 1'b1;
    out_data  = 16'h5678;
    #12;
    chk(!hid_ready && !out_ready, "rst_ready",
        {30'b0, out_ready, hid_ready}, 32'd0);
    chk(!lut_en && lut_in == '0, "rst_lut",
        {15'b0, lut_en, lut_in}, 32'd0);
    chk(!busy && !hid_resp_valid && !out_resp_valid, "rst_resp",
        {29'b0, busy, hid_resp_valid, out_resp_valid}, 32'd0);
    chk(hid_resp_data == '0 && out_resp_data == '0, "rst_data",
        {hid_resp_data, out_resp_data}, 32'd0);
    chk(conflict_cnt == 16'd0, "rst_conflict",
        32'(conflict_cnt), 32'd0);
    hid_valid = 1'b0;
    out_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Solo hid, back to back.
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'(i), 1'b0, '0, 1'b0, 1, 1'b1, "solo");
    idle(LAT + 1);

    // Contention: hid x4, out, hid x4, out, hid x2.
    c0  = conflict_cnt;
    pat = 16'b0000_0010_0001_0000;
    for (int i = 0; i < 12; i++)
      step(1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0200 + 16'(i),
           1'b0, pat[i] ? 2 : 1, 1'b1, "contend");
    idle(1);
    chk(conflict_cnt == c0 + 16'd12, "contend_conflict",
        32'(conflict_cnt), 32'(c0 + 16'd12));
    idle(LAT);

    // Interleave single-valid requests, then watch busy fall.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(1'b1, 16'h0010, 1'b0, '0, 1'b0, 1, 1'b1, "ilv");
      else
        step(1'b0, '0, 1'b1, 16'h0020, 1'b0, 2, 1'b1, "ilv");
    end
    for (int i = 0; i < LAT + 2; i++) begin
      idle(1);
      chk(busy == (cyc <= last_xfer + LAT), "ilv_busy",
          32'(busy), 32'(cyc <= last_xfer + LAT));
    end

    // Flush: only the lookup at the tail survives.
    step(1'b1, 16'h0A01, 1'b0, '0, 1'b0, 1, 1'b1, "fl");
    step(1'b0, '0, 1'b1, 16'h0B02, 1'b0, 2, 1'b0, "fl");
    step(1'b1, 16'h0C03, 1'b0, '0, 1'b0, 1, 1'b0, "fl");
    step(1'b1, 16'h0D04, 1'b1, 16'h0E05, 1'b1, 0, 1'b0, "fl_blk");
    idle(1);
    chk(!busy, "fl_busy", 32'(busy), 32'd0);
    idle(LAT + 1);

    // Async reset in the middle of a burst.
    step(1'b1, 16'h0301, 1'b0, '0, 1'b0, 1, 1'b0, "ar");
    step(1'b1, 16'h0302, 1'b1, 16'h0303, 1'b0, 1, 1'b0, "ar");
    chk(busy, "ar_busy_pre", 32'(busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk(!busy && !lut_en && lut_in == '0, "ar_busy_lut",
        {14'b0, busy, lut_en, lut_in}, 32'd0);
    chk(!hid_ready && !out_ready, "ar_ready",
        {30'b0, out_ready, hid_ready}, 32'd0);
    chk(!hid_resp_valid && !out_resp_valid, "ar_resp",
        {30'b0, hid_resp_valid, out_resp_valid}, 32'd0);
    chk(conflict_cnt == 16'd0, "ar_conflict",
        32'(conflict_cnt), 32'd0);
    sb.delete();
    hid_valid = 1'b0;
    out_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    step(1'b0, '0, 1'b1, 16'h0404, 1'b0, 2, 1'b1, "ar_new");
    idle(LAT + 2);

    // Saturation: out wins every fifth cycle throughout.
    for (int i = 0; i < 70000; i++)
      step(1'b1, 16'(i), 1'b1, ~16'(i), 1'b0,
           (i % 5 == 4) ? 2 : 1, 1'b1, "sat");
    idle(LAT + 2);
    chk(conflict_cnt == 16'hFFFF, "sat_conflict",
        32'(conflict_cnt), 32'h0000FFFF);
    chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_arbiter.md
# lut_arbiter

Shares the single activation LUT between two requesters: the hidden-layer path (reg holder entries after the layer-1 MAC pass) and the output-layer path (GSRAM entries after the layer-2 accumulation). The block arbitrates one lookup per cycle and forwards it to the fixed-latency LUT. It returns each result to the requester that issued it, in issue order. It sits between the sequencing controller's datapath muxes and the LUT, and replaces the controller-driven LUT source mux.

## Interface
- DATA_W, 16: width of LUT input/output words
- LUT_LAT, 1: LUT read latency in cycles (≥1)
- STARVE_MAX, 4: consecutive lost-arbitration cycles before the output path is forced ahead (1..255)

Ports:
- clk  in  1  single clock; everything is posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- flush  in  1  synchronous; drops all in-flight lookups and blocks new grants this cycle
- hid_valid  in  1  hidden-layer lookup request
- hid_data  in  DATA_W  hidden-layer pre-activation value
- hid_ready  out  1  hidden-layer request accepted this cycle when high with hid_valid
- hid_resp_valid  out  1  hidden-layer result valid (single-cycle pulse, no backpressure)
- hid_resp_data  out  DATA_W  hidden-layer activated value
- out_valid / out_data / out_ready / out_resp_valid / out_resp_data: same as hid_*, output-layer path
- lut_en  out  1  LUT read strobe
- lut_in  out  DATA_W  LUT address/operand
- lut_out  in  DATA_W  LUT result, valid LUT_LAT cycles after lut_en
- busy  out  1  at least one lookup in flight
- conflict_cnt  out  16  saturating count of cycles with both valids high

## Operation
- A transfer happens when valid and ready are both high in the same cycle. At most one transfer occurs per cycle.
- Arbitration:
  - Default priority is hid over out.
  - starve_cnt (8 bit) increments each cycle out_valid=1 and out_ready=0.
  - starve_cnt clears on an out transfer, or in any cycle out_valid=0.
  - starve = (starve_cnt ≥ STARVE_MAX). While starve=1, out wins over hid.
- Ready logic (combinational from the valids, so no ready→valid loop exists):
  - hid_ready = !flush & (!out_valid | !starve)
  - out_ready = !flush & (!hid_valid | starve)
- Issue: in the transfer cycle, lut_en=1 and lut_in = winner's data (combinational). When there is no transfer, lut_en=0 and lut_in=0.
- Tag pipeline: an LUT_LAT-deep shift register of {valid, id}, where id 0 = hid and 1 = out. The issue cycle pushes {1, winner}; a cycle with no transfer pushes {0, x}.
- Response: when the tail entry is valid, the matching *_resp_valid is 1 and *_resp_data = lut_out. The other path's resp_valid is 0 and its resp_data is 0.
- flush: clears every tag valid bit at the clock edge, so no response is produced for lookups issued before or during the flush cycle. Does not clear starve_cnt or conflict_cnt.
- busy = OR of all tag valid bits.
- conflict_cnt increments when hid_valid & out_valid, and saturates at 0xFFFF.

## Timing
- Reset values:
  - hid_resp_valid, out_resp_valid, lut_en, busy = 0
  - hid_resp_data, out_resp_data, lut_in = 0
  - conflict_cnt = 0, starve_cnt = 0, all tags invalid
  - hid_ready and out_ready are 0 while reset is low
- Latency: transfer in cycle N gives resp_valid in cycle N+LUT_LAT. Throughput is 1 lookup/cycle, sustained.
- Order: responses emerge in issue order; no reordering between paths.
- Simultaneous events:
  - flush with a valid request: no transfer, and starve_cnt still counts if out_valid=1.
  - A response at the tail coincident with flush is still delivered, because the tail is read before the clear.
- Reset asserted mid-burst: in-flight lookups are discarded with no response, and the state machine restarts at idle on deassertion.
- starve_cnt saturates at 255 and does not wrap.

## Structure
- Shared package nn_pkg:
  - DATA_W default
  - LUT_LAT default
  - requester id enum {REQ_HID=0, REQ_OUT=1}
  - the tag struct {valid, id}
- Sub-module lut_tag_pipe(LUT_LAT): shift register of tags with a synchronous clear input driven by flush. The arbiter, counters and response demux stay in lut_arbiter.

## Test plan
- Solo hid: 10 back-to-back hid requests with data 0..9 and out idle → hid_ready stays 1, and 10 hid_resp_valid pulses arrive starting 1 cycle after the first transfer, carrying the LUT image of 0..9 in order.
- Contention with STARVE_MAX=4: both valid for 12 cycles → grant pattern is hid×4, out, hid×4, out, hid×2, and conflict_cnt=12.
- Interleave order: alternate hid=0x0010 and out=0x0020 with single valids → responses alternate paths with correct data, and busy drops exactly LUT_LAT cycles after the last transfer.
- Flush: issue 3 lookups with LUT_LAT=3, then pulse flush on the cycle after the third → at most the first response (if at the tail) appears, the later ones never do, and busy=0 next cycle.
- Async reset mid-stream: assert reset between clock edges during a burst → all outputs go to 0 without waiting for a clock edge, and after release the first new request gets its response at N+LUT_LAT.
- Saturation: hold both valids for 70000 cycles → conflict_cnt=0xFFFF, and out is still granted every 5th cycle.
